score_display_ctrl: RTL and testbench

- Sequencing controller for the two-digit score readout on the board's pair of 7-segment displays.
- Accepts a binary value through a load strobe and converts it to tens/ones BCD with a multi-cycle repeated-subtraction FSM.
- Registers the two digit codes that feed two segment_display decoder instances.
- Adds leading-zero blanking and a blink mode. Blanking uses code 4'd15, which the decoder renders as all segments off.

---
 rtl/score_display_ctrl.sv | 94 +++++++++
 tb/tb_score_display_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/score_display_ctrl.sv
// Two-digit score readout sequencer: binary load -> BCD by repeated subtraction,
// registered digit codes with leading-zero blanking and blink.
module score_display_ctrl #(
  parameter int CLKS_PER_BLINK     = 12500000,
  parameter bit BLANK_LEADING_ZERO = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [6:0] i_Value,
  input  logic       i_Load,
  input  logic       i_Blink_En,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Overflow,
  output logic [3:0] o_Digit_Tens,
  output logic [3:0] o_Digit_Ones
);
  localparam int         CW      = (CLKS_PER_BLINK > 1) ? $clog2(CLKS_PER_BLINK) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BLINK - 1);
  localparam logic [3:0] BLANK   = 4'd15;

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t        state;
  logic [6:0]    rem;
  logic [3:0]    tens;
  logic          ovf;
  logic [1:0][3:0] held, held_d;  // [1] = tens, [0] = ones
  logic [CW-1:0] cnt;
  logic          phase_on, phase_on_d;
  logic [3:0]    tens_d, ones_d;

  // Outputs are registered from next-state held digits and phase so the
  // Done edge already shows the new value.
  always_comb begin
    held_d = held;
    if (state == UPDATE) held_d = {tens, rem[3:0]};
    phase_on_d = 1'b1;
    if (i_Blink_En) phase_on_d = (cnt == CNT_MAX) ? ~phase_on : phase_on;
    tens_d = BLANK;
    ones_d = BLANK;
    if (phase_on_d) begin
      ones_d = held_d[0];
      tens_d = (BLANK_LEADING_ZERO && held_d[1] == 4'd0) ? BLANK : held_d[1];
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state        <= IDLE;
      rem          <= '0;
      tens         <= '0;
      ovf          <= 1'b0;
      held         <= {BLANK, BLANK};
      o_Busy       <= 1'b0;
      o_Done       <= 1'b0;
      o_Overflow   <= 1'b0;
      cnt          <= '0;
      phase_on     <= 1'b1;
      o_Digit_Tens <= BLANK;
      o_Digit_Ones <= BLANK;
    end else begin
      o_Done <= 1'b0;
      unique case (state)
        IDLE: if (i_Load) begin
          rem    <= (i_Value > 7'd99) ? 7'd99 : i_Value;
          tens   <= '0;
          ovf    <= (i_Value > 7'd99);
          o_Busy <= 1'b1;
          state  <= CONVERT;
        end
        CONVERT: if (rem >= 7'd10) begin
          rem  <= rem - 7'd10;
          tens <= tens + 4'd1;
        end else begin
          state <= UPDATE;
        end
        UPDATE: begin
          o_Overflow <= ovf;
          o_Done     <= 1'b1;
          o_Busy     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
      held     <= held_d;
      phase_on <= phase_on_d;
      if (!i_Blink_En || cnt == CNT_MAX) cnt <= '0;
      else                               cnt <= cnt + 1'b1;
      o_Digit_Tens <= tens_d;
      o_Digit_Ones <= ones_d;
    end
  end
endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl: table vectors, hand sequences and random
// stimulus against an event-level reference model.
module tb_score_display_ctrl;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst, load, blink_en;
  logic [6:0] value;
  logic       busy, done, ovf, busy1, done1, ovf1;
  logic [3:0] d_tens, d_ones, d_tens1, d_ones1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  score_display_ctrl #(.CLKS_PER_BLINK(N), .BLANK_LEADING_ZERO(1'b1)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Value(value), .i_Load(load), .i_Blink_En(blink_en),
    .o_Busy(busy), .o_Done(done), .o_Overflow(ovf),
    .o_Digit_Tens(d_tens), .o_Digit_Ones(d_ones));

  score_display_ctrl #(.CLKS_PER_BLINK(N), .BLANK_LEADING_ZERO(1'b0)) dut_nb (
    .i_Clk(clk), .i_Rst(rst), .i_Value(value), .i_Load(load), .i_Blink_En(blink_en),
    .o_Busy(busy1), .o_Done(done1), .o_Overflow(ovf1),
    .o_Digit_Tens(d_tens1), .o_Digit_Ones(d_ones1));

  // reference model: conversion is an event scheduled at load edge + t + 2
  int edge_n = 0, done_edge = -1, bk = 0;
  int p_t, p_o, h_t = 15, h_o = 15;
  bit p_ovf, m_ovf, m_done, m_busy;

  task automatic model_step();
    int v;
    edge_n++;
    if (rst) begin
      h_t = 15; h_o = 15; m_ovf = 0; m_done = 0; m_busy = 0; done_edge = -1; bk = 0;
      return;
    end
    m_done = 0;
    if (done_edge == edge_n) begin
      h_t = p_t; h_o = p_o; m_ovf = p_ovf; m_done = 1; m_busy = 0; done_edge = -1;
    end else if (!m_busy && load) begin
      v = (int'(value) > 99) ? 99 : int'(value);
      p_t = v / 10; p_o = v % 10; p_ovf = (value > 99);
      done_edge = edge_n + p_t + 2; m_busy = 1;
    end
    bk = blink_en ? bk + 1 : 0;
  endtask

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    bit off;
    @(posedge clk);
    model_step();
    @(negedge clk);
    off = blink_en && ((bk / N) % 2 == 1);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("ovf",  ovf,  m_ovf);
    chk("tens", d_tens, off ? 15 : (h_t == 0 ? 15 : h_t));
    chk("ones", d_ones, off ? 15 : h_o);
    chk("tens_nb", d_tens1, off ? 15 : h_t);
    chk("ones_nb", d_ones1, off ? 15 : h_o);
  endtask

  // load at E0, return k where o_Done is seen after edge E0+k (-1 on timeout)
  task automatic run_load(input int v, output int lat);
    value = 7'(v); load = 1; tick(); load = 0;
    lat = 0;
    while (!done && lat < 20) begin tick(); lat++; end
    if (!done) lat = -1;
  endtask

  typedef struct { int v; int t; int o; int t_nb; int ov; int lat; } vec_t;
  vec_t vecs[9];

  initial begin
    int lat;
    vecs = '{'{47, 4, 7, 4, 0, 6}, '{5, 15, 5, 0, 0, 2}, '{120, 9, 9, 9, 1, 11},
             '{0, 15, 0, 0, 0, 2}, '{99, 9, 9, 9, 0, 11}, '{100, 9, 9, 9, 1, 11},
             '{10, 1, 0, 1, 0, 3}, '{127, 9, 9, 9, 1, 11}, '{9, 15, 9, 0, 0, 2}};
    rst = 1; load = 0; blink_en = 0; value = '0;
    @(negedge clk);
    tick(); tick();
    rst = 0;
    repeat (5) tick();
    chk("rst_tens", d_tens, 15); chk("rst_ones", d_ones, 15);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_ovf", ovf, 0);

    foreach (vecs[i]) begin
      run_load(vecs[i].v, lat);
      chk($sformatf("lat_%0d", vecs[i].v), lat, vecs[i].lat);
      chk($sformatf("vt_%0d", vecs[i].v), d_tens, vecs[i].t);
      chk($sformatf("vo_%0d", vecs[i].v), d_ones, vecs[i].o);
      chk($sformatf("vtnb_%0d", vecs[i].v), d_tens1, vecs[i].t_nb);
      chk($sformatf("vov_%0d", vecs[i].v), ovf, vecs[i].ov);
      tick();
      chk("done_1cyc", done, 0);
    end

    // load while busy is ignored; load during the Done cycle is accepted
    value = 47; load = 1; tick(); load = 0;
    tick(); tick();
    value = 12; load = 1; tick(); load = 0;
    lat = 3;
    while (!done && lat < 20) begin tick(); lat++; end
    chk("ign_lat", lat, 6); chk("ign_t", d_tens, 4); chk("ign_o", d_ones, 7);
    run_load(12, lat);
    chk("dc_lat", lat, 3); chk("dc_t", d_tens, 1); chk("dc_o", d_ones, 2);

    // blink 4 on / 4 off, then reset inside an off phase
    run_load(47, lat);
    tick();
    blink_en = 1;
    for (int j = 1; j <= 13; j++) begin
      tick();
      chk("blink_t", d_tens, ((j / 4) % 2 == 1) ? 15 : 4);
      chk("blink_o", d_ones, ((j / 4) % 2 == 1) ? 15 : 7);
    end
    rst = 1; tick(); rst = 0;
    chk("brst_t", d_tens, 15); chk("brst_o", d_ones, 15); chk("brst_busy", busy, 0);
    run_load(47, lat);
    chk("brst_lat", lat, 6);
    blink_en = 0; tick();
    chk("brst_t2", d_tens, 4);

    // randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      load  = ($urandom_range(0, 3) == 0);
      value = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 39) == 0) blink_en = ~blink_en;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
